// File: rtl/vec_issue_unit_if.sv
// Signal bundle between the vector issue unit and its environment:
// instruction stream, host load/read port, ALU operands/result and writeback status.
interface vec_issue_unit_if #(
    parameter int REG_W = 256,
    parameter int IDX_W = 3
);
    logic             instr_valid;
    logic             instr_ready;
    logic [1:0]       instr_mode;
    logic [IDX_W-1:0] instr_dst;
    logic [IDX_W-1:0] instr_src0;
    logic [IDX_W-1:0] instr_src1;

    logic             ld_valid;
    logic             ld_ready;
    logic [IDX_W-1:0] ld_addr;
    logic [REG_W-1:0] ld_data;

    logic [IDX_W-1:0] rd_addr;
    logic [REG_W-1:0] rd_data;

    logic [REG_W-1:0] op0_value;
    logic [REG_W-1:0] op1_value;
    logic [1:0]       mode;
    logic [REG_W-1:0] alu_out;

    logic             wb_valid;
    logic [IDX_W-1:0] wb_dst;
    logic [15:0]      retired;
    logic             busy;

    modport slave (
        input  instr_valid, instr_mode, instr_dst, instr_src0, instr_src1,
        input  ld_valid, ld_addr, ld_data, rd_addr, alu_out,
        output instr_ready, ld_ready, rd_data, op0_value, op1_value, mode,
        output wb_valid, wb_dst, retired, busy
    );

    modport master (
        output instr_valid, instr_mode, instr_dst, instr_src0, instr_src1,
        output ld_valid, ld_addr, ld_data, rd_addr, alu_out,
        input  instr_ready, ld_ready, rd_data, op0_value, op1_value, mode,
        input  wb_valid, wb_dst, retired, busy
    );
endinterface

// File: rtl/vec_issue_unit.sv
// Issue/writeback stage in front of the 32-lane SIMD ALU: instruction FIFO, vector
// register file with EX->ID forwarding, host load/read port and retirement counter.
module vec_issue_unit #(
    parameter int NUM_REGS   = 8,
    parameter int REG_W      = 256,
    parameter int FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    vec_issue_unit_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [1:0]       mode;
        logic [IDX_W-1:0] dst;
        logic [IDX_W-1:0] src0;
        logic [IDX_W-1:0] src1;
    } instr_t;

    instr_t           fifo_q [FIFO_DEPTH];
    instr_t           fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [REG_W-1:0] regfile_q [NUM_REGS];
    logic [REG_W-1:0] regfile_d [NUM_REGS];

    logic             ex_valid_q, ex_valid_d;
    logic [IDX_W-1:0] ex_dst_q, ex_dst_d;
    logic [REG_W-1:0] op0_q, op0_d;
    logic [REG_W-1:0] op1_q, op1_d;
    logic [1:0]       mode_q, mode_d;

    logic             wb_valid_q, wb_valid_d;
    logic [IDX_W-1:0] wb_dst_q, wb_dst_d;
    logic [15:0]      retired_q, retired_d;
    logic [REG_W-1:0] rd_data_q, rd_data_d;

    logic             instr_ready;
    logic             push;
    logic             pop;
    logic             busy;
    logic             ld_fire;
    logic             fwd0;
    logic             fwd1;
    instr_t           head;

    always_comb begin
        instr_ready = (count_q < CNT_W'(FIFO_DEPTH));
        push        = bus.instr_valid && instr_ready;
        pop         = (count_q != '0);
        busy        = pop || ex_valid_q;
        ld_fire     = bus.ld_valid && !busy;
        head        = fifo_q[rd_ptr_q];

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{mode: bus.instr_mode, dst: bus.instr_dst,
                                 src0: bus.instr_src0, src1: bus.instr_src1};
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        // The instruction in EX writes at this same edge, so its result must bypass the regfile.
        fwd0 = ex_valid_q && (ex_dst_q == head.src0);
        fwd1 = ex_valid_q && (ex_dst_q == head.src1);

        op0_d      = op0_q;
        op1_d      = op1_q;
        mode_d     = mode_q;
        ex_dst_d   = ex_dst_q;
        ex_valid_d = pop;
        if (pop) begin
            op0_d    = fwd0 ? bus.alu_out : regfile_q[head.src0];
            op1_d    = fwd1 ? bus.alu_out : regfile_q[head.src1];
            mode_d   = head.mode;
            ex_dst_d = head.dst;
        end

        // Host loads are only accepted while idle, so they can never collide with a writeback.
        regfile_d = regfile_q;
        if (ex_valid_q) begin
            regfile_d[ex_dst_q] = bus.alu_out;
        end else if (ld_fire) begin
            regfile_d[bus.ld_addr] = bus.ld_data;
        end

        wb_valid_d = ex_valid_q;
        wb_dst_d   = ex_valid_q ? ex_dst_q : wb_dst_q;
        retired_d  = retired_q + 16'(ex_valid_q);
        rd_data_d  = regfile_q[bus.rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                regfile_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_dst_q   <= '0;
            op0_q      <= '0;
            op1_q      <= '0;
            mode_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_dst_q   <= '0;
            retired_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            fifo_q     <= fifo_d;
            regfile_q  <= regfile_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ex_valid_q <= ex_valid_d;
            ex_dst_q   <= ex_dst_d;
            op0_q      <= op0_d;
            op1_q      <= op1_d;
            mode_q     <= mode_d;
            wb_valid_q <= wb_valid_d;
            wb_dst_q   <= wb_dst_d;
            retired_q  <= retired_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.ld_ready    = !busy;
    assign bus.busy        = busy;
    assign bus.op0_value   = op0_q;
    assign bus.op1_value   = op1_q;
    assign bus.mode        = mode_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_dst      = wb_dst_q;
    assign bus.retired     = retired_q;
    assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_vec_issue_unit.sv
// Bench for vec_issue_unit: lane-wise ALU model, operand/writeback scoreboard,
// a vector table for the dependent instruction mix and directed multi-cycle sequences.
module tb_vec_issue_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_issue_unit_if #(.REG_W(256), .IDX_W(3)) bus ();

    vec_issue_unit #(.NUM_REGS(8), .REG_W(256), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [255:0] alu_fn(input logic [255:0] a, input logic [255:0] b,
                                            input logic [1:0] m);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            case (m)
                2'b00:   r[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
                2'b01:   r[8*i +: 8] = a[8*i +: 8] & b[8*i +: 8];
                2'b10:   r[8*i +: 8] = a[8*i +: 8] | b[8*i +: 8];
                default: r[8*i +: 8] = a[8*i +: 8] ^ b[8*i +: 8];
            endcase
        end
        return r;
    endfunction

    assign bus.alu_out = alu_fn(bus.op0_value, bus.op1_value, bus.mode);

    typedef struct {
        logic [2:0]   dst;
        logic [255:0] op0;
        logic [255:0] op1;
        logic [1:0]   mode;
    } sb_t;

    typedef struct {
        logic [1:0]   mode;
        logic [2:0]   dst;
        logic [2:0]   src0;
        logic [2:0]   src1;
        logic [255:0] expect_val;
    } vec_t;

    sb_t          sb_q[$];
    logic [255:0] model_rf [8];
    vec_t         vectors [6];

    int checks = 0;
    int errors = 0;
    int wb_count = 0;
    int run_len = 0;
    int max_run = 0;
    logic [255:0] prev_op0 = '0;
    logic [255:0] prev_op1 = '0;
    logic [1:0]   prev_mode = '0;

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            if (errors <= 20)
                $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    // Writeback monitor: each pulse must match the oldest issued instruction's ALU inputs.
    always @(negedge clk) begin
        sb_t e;
        if (!rst && bus.wb_valid) begin
            wb_count++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_wb: wb_dst=%0d with no instruction outstanding",
                         bus.wb_dst);
            end else begin
                e = sb_q.pop_front();
                checkOutput("wb_dst", bus.wb_dst, e.dst);
                checkOutput("op0_value", prev_op0, e.op0);
                checkOutput("op1_value", prev_op1, e.op1);
                checkOutput("mode", prev_mode, e.mode);
            end
        end else begin
            run_len = 0;
        end
        prev_op0  = bus.op0_value;
        prev_op1  = bus.op1_value;
        prev_mode = bus.mode;
    end

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.ld_valid = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 8; i++) model_rf[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [2:0] d,
                                 input logic [2:0] s0, input logic [2:0] s1);
        sb_t e;
        @(negedge clk);
        checkOutput("instr_ready", bus.instr_ready, 1);
        bus.instr_valid = 1'b1;
        bus.instr_mode  = m;
        bus.instr_dst   = d;
        bus.instr_src0  = s0;
        bus.instr_src1  = s1;
        e.dst  = d;
        e.op0  = model_rf[s0];
        e.op1  = model_rf[s1];
        e.mode = m;
        sb_q.push_back(e);
        model_rf[d] = alu_fn(e.op0, e.op1, m);
    endtask

    task automatic endStimulus();
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            #1;
            if (!bus.busy && sb_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: busy=%0b outstanding=%0d after 20 cycles",
                     bus.busy, sb_q.size());
        end
    endtask

    task automatic loadReg(input logic [2:0] a, input logic [255:0] d, input logic accept);
        @(negedge clk);
        checkOutput("ld_ready", bus.ld_ready, accept);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        if (bus.ld_ready) model_rf[a] = d;
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic readReg(input string name, input logic [2:0] a, input logic [255:0] required);
        @(negedge clk);
        bus.rd_addr = a;
        @(negedge clk);
        checkOutput(name, bus.rd_data, required);
    endtask

    initial begin
        logic [15:0] base;
        int          wb_base;

        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_mode  = '0;
        bus.instr_dst   = '0;
        bus.instr_src0  = '0;
        bus.instr_src1  = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.rd_addr     = '0;

        vectors[0] = '{2'b00, 3'd3, 3'd1, 3'd2, {32{8'h00}}};
        vectors[1] = '{2'b11, 3'd4, 3'd1, 3'd2, {32{8'hFE}}};
        vectors[2] = '{2'b01, 3'd5, 3'd4, 3'd1, {32{8'h00}}};
        vectors[3] = '{2'b10, 3'd6, 3'd1, 3'd4, {32{8'hFF}}};
        vectors[4] = '{2'b00, 3'd7, 3'd1, 3'd1, {32{8'h02}}};
        vectors[5] = '{2'b11, 3'd0, 3'd0, 3'd2, {32{8'hFF}}};

        doReset();
        @(negedge clk);
        checkOutput("rst_instr_ready", bus.instr_ready, 1);
        checkOutput("rst_ld_ready", bus.ld_ready, 1);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_wb_valid", bus.wb_valid, 0);
        checkOutput("rst_retired", bus.retired, 0);
        checkOutput("rst_op0", bus.op0_value, 0);
        checkOutput("rst_op1", bus.op1_value, 0);
        checkOutput("rst_mode", bus.mode, 0);
        checkOutput("rst_wb_dst", bus.wb_dst, 0);
        checkOutput("rst_rd_data", bus.rd_data, 0);

        $display("[TB] dependent instruction table");
        loadReg(3'd1, {32{8'h01}}, 1'b1);
        loadReg(3'd2, {32{8'hFF}}, 1'b1);
        for (int i = 0; i < 6; i++)
            applyStimulus(vectors[i].mode, vectors[i].dst, vectors[i].src0, vectors[i].src1);
        endStimulus();
        waitIdle();
        for (int i = 0; i < 6; i++)
            readReg("table_result", vectors[i].dst, vectors[i].expect_val);
        checkOutput("table_retired", bus.retired, 6);
        checkOutput("table_wb_dst", bus.wb_dst, 0);

        $display("[TB] back-to-back throughput");
        base    = bus.retired;
        wb_base = wb_count;
        max_run = 0;
        for (int i = 0; i < 5; i++) applyStimulus(2'b00, 3'd3, 3'd3, 3'd1);
        endStimulus();
        waitIdle();
        checkOutput("tput_retired", bus.retired, base + 16'd5);
        checkOutput("tput_wb_count", wb_count - wb_base, 5);
        checkOutput("tput_consecutive", max_run, 5);
        readReg("tput_chain", 3'd3, {32{8'h05}});

        $display("[TB] host load while busy");
        applyStimulus(2'b11, 3'd6, 3'd6, 3'd6);
        endStimulus();
        loadReg(3'd6, {32{8'hAA}}, 1'b0);
        waitIdle();
        readReg("busy_load_dropped", 3'd6, {32{8'h00}});
        loadReg(3'd6, {32{8'hAA}}, 1'b1);
        readReg("idle_load_written", 3'd6, {32{8'hAA}});

        $display("[TB] retired counter wrap");
        doReset();
        for (int i = 0; i < 65535; i++) applyStimulus(2'b10, 3'd0, 3'd0, 3'd0);
        endStimulus();
        waitIdle();
        checkOutput("retired_max", bus.retired, 16'hFFFF);
        applyStimulus(2'b10, 3'd0, 3'd0, 3'd0);
        endStimulus();
        waitIdle();
        checkOutput("retired_wrap", bus.retired, 0);

        $display("[TB] reset with instructions in flight");
        loadReg(3'd1, {32{8'h01}}, 1'b1);
        loadReg(3'd2, {32{8'hFF}}, 1'b1);
        applyStimulus(2'b00, 3'd3, 3'd1, 3'd2);
        applyStimulus(2'b11, 3'd4, 3'd1, 3'd2);
        doReset();
        repeat (5) @(negedge clk);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_retired", bus.retired, 0);
        for (int i = 0; i < 8; i++) readReg("midrst_reg", 3'(i), {256{1'b0}});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/vec_issue_unit.md
Name: vec_issue_unit

Overview:
- Issue and writeback stage directly upstream of the 256-bit, 32-lane SIMD ALU.
- Holds an 8-entry x 256-bit vector register file and a small instruction FIFO.
- Each cycle it reads two source registers, drives op0_value, op1_value and mode into the ALU, captures alu_out, and writes the result back to the destination register.
- A host load/read port fills and inspects registers.

Parameters:
- NUM_REGS, 8, number of vector registers; register index width is log2(NUM_REGS).
- REG_W, 256, register and ALU operand width in bits; fixed at 32 lanes x 8 bits.
- FIFO_DEPTH, 4, instruction FIFO entries; must be a power of 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  FIFO can accept; instruction accepted when valid && ready.
- instr_mode  in  2  00 add, 01 and, 10 or, 11 xor (the ALU's encoding).
- instr_dst  in  3  destination register.
- instr_src0  in  3  source of op0.
- instr_src1  in  3  source of op1.
- ld_valid  in  1  host register write request.
- ld_ready  out  1  host write accepted when ld_valid && ld_ready.
- ld_addr  in  3  host write register.
- ld_data  in  256  host write data.
- rd_addr  in  3  host read register.
- rd_data  out  256  registered read of regfile[rd_addr], one-cycle latency.
- op0_value  out  256  to ALU, registered.
- op1_value  out  256  to ALU, registered.
- mode  out  2  to ALU, registered.
- alu_out  in  256  combinational ALU result for the current op0_value/op1_value/mode.
- wb_valid  out  1  one-cycle pulse: a result was written this cycle.
- wb_dst  out  3  register written; valid with wb_valid.
- retired  out  16  count of written-back instructions; wraps at 65535 -> 0.
- busy  out  1  FIFO non-empty or EX stage occupied.

Behaviour:
- Reset (rst=1 at an edge):
  - Register file, FIFO pointers and count, and ex_valid cleared.
  - op0_value, op1_value, mode, rd_data, wb_dst and retired forced to 0; wb_valid forced to 0.
  - After reset: instr_ready=1, ld_ready=1, busy=0.
  - Reset mid-operation discards all queued and in-flight instructions; no writeback occurs on that edge.
- FIFO:
  - instr_ready = (count < FIFO_DEPTH).
  - Push and pop in the same cycle is allowed when full: ready still reflects the pre-edge count, so a full FIFO rejects the push.
  - Pointers wrap modulo FIFO_DEPTH.
- Issue (ID stage):
  - If the FIFO is non-empty, the head is popped every cycle; there are no structural stalls.
  - Operands are read from the register file with a forwarding rule: if ex_valid and ex_dst equals a source, that operand takes alu_out instead of the register file.
  - src0 == src1 == ex_dst forwards both operands.
  - At the edge: op0_value, op1_value, mode and ex_dst are loaded, and ex_valid=1.
  - With an empty FIFO: ex_valid=0 and the operand registers hold their values.
- Execute/writeback (EX stage):
  - When ex_valid=1, at the next edge regfile[ex_dst] <= alu_out, wb_valid=1, wb_dst=ex_dst, and retired increments.
  - Issue-to-writeback latency: an instruction popped in cycle t drives the ALU in t+1 and is written at the end of t+1.
  - Minimum FIFO push-to-writeback is 3 edges.
  - Throughput is 1 per cycle.
- Host port:
  - ld_ready = !busy.
  - A load writes regfile[ld_addr] <= ld_data at the edge.
  - Loads and instructions never write in the same cycle.
  - A load accepted in the same cycle as an instruction push is legal; the load completes first because EX is empty.
  - rd_data <= regfile[rd_addr] each cycle, pre-write value (read-before-write).
- Arithmetic: performed by the ALU, lane-wise 8-bit. The add carry is discarded per lane; this block does not alter the data.
- Register 0 is a normal register, not hardwired.

Test Plan:
- Reset with instructions queued -> busy=0, wb_valid never pulses, retired=0, rd_data of every register reads 0.
- Load r1 with 0x01 in all bytes and r2 with 0xFF in all bytes, then issue add r3=r1+r2 -> op0_value/op1_value match r1/r2 one cycle after the pop; r3 reads 0x00 in all bytes (per-lane wrap); wb_dst=3, retired=1.
- Back-to-back dependency: xor r4=r1^r2, then and r5=r4&r1 in consecutive cycles -> the second instruction's op0_value = 0xFE in all bytes (forwarded); r5 = 0x00 in all bytes.
- Hold instr_valid high with a stalled-free pipeline -> 5 pushes in 5 cycles produce 5 consecutive wb_valid pulses and retired=5. Also assert that instr_ready stays 1 throughout.
- Preload retired to 65535 via 65535 or-ops, then one more -> retired=0.
- ld_valid while busy=1 -> ld_ready=0 and the register is unchanged; the same load retried after busy=0 -> written.
